// File: rtl/instr_fetch_pkg.sv
// +----------------------------------------------------------------------------+
// | instr_fetch_pkg                                                            |
// | Shared types, PC-select encoding and the 6502 instruction-length function. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package instr_fetch_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  opcode_t;
  typedef logic [1:0]  ilen_t;

  typedef enum logic [1:0] {
    PS_HOLD = 2'd0,
    PS_INC  = 2'd1,
    PS_ABS  = 2'd2
  } ps_t;

  typedef enum logic [2:0] {
    ST_OP    = 3'd0,
    ST_B1    = 3'd1,
    ST_B2    = 3'd2,
    ST_B3    = 3'd3,
    ST_ISSUE = 3'd4
  } fetch_state_t;

  localparam opcode_t c_jmp_abs_opc = 8'h4C;

  // Decoded from the aaabbbcc opcode layout; anything undocumented is 1 byte.
  function automatic ilen_t op_len(input opcode_t op);
    ilen_t len;
    len = 2'd1;
    case (op[1:0])
      2'b01: begin
        case (op[4:2])
          3'b010:                 len = (op == 8'h89) ? 2'd1 : 2'd2;
          3'b011, 3'b110, 3'b111: len = 2'd3;
          default:                len = 2'd2;
        endcase
      end
      2'b10: begin
        case (op[4:2])
          3'b000:         len = (op == 8'hA2) ? 2'd2 : 2'd1;
          3'b001, 3'b101: len = 2'd2;
          3'b011:         len = 2'd3;
          3'b111:         len = (op == 8'h9E) ? 2'd1 : 2'd3;
          default:        len = 2'd1;
        endcase
      end
      2'b00: begin
        case (op[4:2])
          3'b000: begin
            if (op == 8'h20)
              len = 2'd3;
            else if (op == 8'hA0 || op == 8'hC0 || op == 8'hE0)
              len = 2'd2;
            else
              len = 2'd1;
          end
          3'b001: len = (op == 8'h24 || op == 8'h84 || op == 8'hA4 ||
                         op == 8'hC4 || op == 8'hE4) ? 2'd2 : 2'd1;
          3'b011: len = (op == 8'h0C) ? 2'd1 : 2'd3;
          3'b100: len = 2'd2;
          3'b101: len = (op == 8'h94 || op == 8'hB4) ? 2'd2 : 2'd1;
          3'b111: len = (op == 8'hBC) ? 2'd3 : 2'd1;
          default: len = 2'd1;
        endcase
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_op_length.sv
// +----------------------------------------------------------------------------+
// | op_length                                                                  |
// | Combinational opcode -> instruction length (1..3 bytes).                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module op_length
  import instr_fetch_pkg::*;
(
  input  opcode_t op_i,
  output ilen_t   len_o
);

  assign len_o = op_len(op_i);

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// +----------------------------------------------------------------------------+
// | instr_fetch                                                                |
// | Byte-serial 6502 fetch sequencer driving the PC and issuing instructions.  |
// | Option: FETCH_JMP_REDIRECT_EN redirects the PC on JMP abs from fetch.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = 16'h0400
) (
  input  logic        clk,
  input  logic        rst,
  input  addr_t       pc_cur,
  output ps_t         ps,
  output addr_t       pc_target,
  output addr_t       mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        flush,
  input  addr_t       flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output opcode_t     instr_opcode,
  output logic [15:0] instr_operand,
  output ilen_t       instr_len,
  output addr_t       instr_pc
);

  fetch_state_t state_q;
  opcode_t      opcode_q;
  logic [7:0]   lo_q;
  logic [7:0]   hi_q;
  ilen_t        len_q;
  addr_t        pc_q;
  logic         valid_q;
  ilen_t        len_d;

  op_length u_op_length (
    .op_i  (mem_data),
    .len_o (len_d)
  );

  assign mem_addr      = pc_cur;
  assign instr_valid   = valid_q;
  assign instr_opcode  = opcode_q;
  assign instr_operand = {hi_q, lo_q};
  assign instr_len     = len_q;
  assign instr_pc      = pc_q;

  always_comb begin
    ps        = PS_HOLD;
    pc_target = '0;
    if (rst) begin
      ps        = PS_ABS;
      pc_target = RESET_PC;
    end else if (flush) begin
      ps        = PS_ABS;
      pc_target = flush_pc;
    end else begin
      case (state_q)
        ST_OP:    ps = PS_INC;
        ST_B1:    ps = (len_d == 2'd1) ? PS_HOLD : PS_INC;
        ST_B2:    ps = (len_q == 2'd2) ? PS_HOLD : PS_INC;
        ST_B3: begin
`ifdef FETCH_JMP_REDIRECT_EN
          if (opcode_q == c_jmp_abs_opc) begin
            ps        = PS_ABS;
            pc_target = {mem_data, lo_q};
          end
`endif
        end
        ST_ISSUE: ps = (valid_q && instr_ready) ? PS_INC : PS_HOLD;
        default:  ps = PS_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OP;
      valid_q  <= 1'b0;
      opcode_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      len_q    <= '0;
      pc_q     <= '0;
    end else if (flush) begin
      state_q <= ST_OP;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_OP: begin
          pc_q    <= pc_cur;
          state_q <= ST_B1;
        end
        ST_B1: begin
          // Operand bytes are cleared here so short instructions report zeros.
          opcode_q <= mem_data;
          len_q    <= len_d;
          lo_q     <= '0;
          hi_q     <= '0;
          if (len_d == 2'd1) begin
            state_q <= ST_ISSUE;
            valid_q <= 1'b1;
          end else begin
            state_q <= ST_B2;
          end
        end
        ST_B2: begin
          lo_q <= mem_data;
          if (len_q == 2'd2) begin
            state_q <= ST_ISSUE;
            valid_q <= 1'b1;
          end else begin
            state_q <= ST_B3;
          end
        end
        ST_B3: begin
          hi_q    <= mem_data;
          state_q <= ST_ISSUE;
          valid_q <= 1'b1;
        end
        ST_ISSUE: begin
          // pc_cur already points at the next opcode, so fetch resumes at B1.
          if (valid_q && instr_ready) begin
            valid_q <= 1'b0;
            pc_q    <= pc_cur;
            state_q <= ST_B1;
          end
        end
        default: begin
          state_q <= ST_OP;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// +----------------------------------------------------------------------------+
// | tb_instr_fetch                                                             |
// | Self-checking bench: PC/memory environment plus instruction-stream model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  addr_t       pc_cur = '0;
  ps_t         ps;
  addr_t       pc_target;
  addr_t       mem_addr;
  logic [7:0]  mem_data = '0;
  logic        flush = 1'b0;
  addr_t       flush_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  opcode_t     instr_opcode;
  logic [15:0] instr_operand;
  ilen_t       instr_len;
  addr_t       instr_pc;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  logic [7:0] mem [0:65535];

  typedef struct {
    logic [7:0]  op;
    logic [1:0]  len;
    logic [15:0] opd;
    logic [15:0] pc;
    int unsigned cyc;
  } issue_t;
  issue_t got[$];

  logic [7:0] picks [0:33] = '{
    8'hEA, 8'h00, 8'h0A, 8'h18, 8'h60, 8'h40, 8'h8A, 8'h02, 8'hFF, 8'h89, 8'h9E, 8'h80,
    8'hA9, 8'hA2, 8'hA0, 8'h85, 8'hB5, 8'hB6, 8'hA1, 8'hB1, 8'hD0, 8'h10, 8'h24, 8'h94,
    8'hAD, 8'h20, 8'h6C, 8'hBD, 8'hB9, 8'hBE, 8'h8C, 8'hEE, 8'h2C, 8'hBC};

  instr_fetch #(.RESET_PC(16'h0400)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_cur        (pc_cur),
    .ps            (ps),
    .pc_target     (pc_target),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_len     (instr_len),
    .instr_pc      (instr_pc)
  );

  always #5 clk = ~clk;

  // Program counter and synchronous memory surrounding the fetch unit.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    mem_data <= mem[mem_addr];
    case (ps)
      PS_INC:  pc_cur <= pc_cur + 16'd1;
      PS_ABS:  pc_cur <= pc_target;
      default: pc_cur <= pc_cur;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready)
      got.push_back('{instr_opcode, instr_len, instr_operand, instr_pc, cyc});
  end

  // 6502 instruction lengths for every opcode this bench places in memory.
  function automatic logic [1:0] ref_len(input logic [7:0] op);
    case (op)
      8'hA9, 8'hA2, 8'hA0, 8'h85, 8'hB5, 8'hB6, 8'hA1, 8'hB1,
      8'hD0, 8'h10, 8'h24, 8'h94:                              return 2'd2;
      8'hAD, 8'h20, 8'h6C, 8'hBD, 8'hB9, 8'hBE, 8'h8C, 8'hEE,
      8'h2C, 8'hBC, 8'h4C:                                     return 2'd3;
      default:                                                 return 2'd1;
    endcase
  endfunction

  function automatic void expect_at(input logic [15:0] a, output issue_t e);
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    e.op  = mem[a];
    e.len = ref_len(mem[a]);
    e.opd = {(e.len == 2'd3) ? mem[a2] : 8'h00, (e.len >= 2'd2) ? mem[a1] : 8'h00};
    e.pc  = a;
    e.cyc = 0;
  endfunction

  function automatic logic [15:0] next_pc(input issue_t e);
`ifdef FETCH_JMP_REDIRECT_EN
    if (e.op == 8'h4C) return e.opd;
`endif
    return e.pc + {14'd0, e.len};
  endfunction

  task automatic wait_count(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (got.size() >= n) ok = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    int unsigned c0;
    bit ok;
    @(posedge clk); #1;
    rst = 1'b1; instr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || instr_opcode !== 8'h00 || instr_operand !== 16'h0000 ||
        instr_len !== 2'd0 || instr_pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs got v=%b op=%h opd=%h len=%0d pc=%h exp all zero",
               instr_valid, instr_opcode, instr_operand, instr_len, instr_pc);
    end
    checks++;
    if (ps !== PS_ABS || pc_target !== 16'h0400) begin
      errors++;
      $display("FAIL reset_pcsel got ps=%0d tgt=%h exp ps=%0d tgt=0400", ps, pc_target, PS_ABS);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    got.delete();
    c0 = cyc;
    @(negedge clk);
    checks++;
    if (pc_cur !== 16'h0400) begin
      errors++;
      $display("FAIL reset_pc got %h exp 0400", pc_cur);
    end
    wait_count(1, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL first_issue_timeout got 0 issues exp 1");
      return;
    end
    checks++;
    if (got[0].op !== 8'hEA || got[0].len !== 2'd1 || got[0].opd !== 16'h0000 ||
        got[0].pc !== 16'h0400 || (got[0].cyc - c0) != 2) begin
      errors++;
      $display("FAIL first_issue got op=%h len=%0d opd=%h pc=%h lat=%0d exp EA 1 0000 0400 lat=2",
               got[0].op, got[0].len, got[0].opd, got[0].pc, got[0].cyc - c0);
    end
  endtask

  task automatic test_program();
    bit ok;
    issue_t e;
    logic [15:0] a;
    wait_count(3, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL program_timeout got %0d issues exp 3", got.size());
      return;
    end
    a = 16'h0400;
    for (int i = 0; i < 3; i++) begin
      expect_at(a, e);
      checks++;
      if (got[i].op !== e.op || got[i].len !== e.len || got[i].opd !== e.opd || got[i].pc !== e.pc) begin
        errors++;
        $display("FAIL program[%0d] got op=%h len=%0d opd=%h pc=%h exp op=%h len=%0d opd=%h pc=%h",
                 i, got[i].op, got[i].len, got[i].opd, got[i].pc, e.op, e.len, e.opd, e.pc);
      end
      if (i > 0) begin
        checks++;
        if ((got[i].cyc - got[i-1].cyc) != (e.len + 1)) begin
          errors++;
          $display("FAIL program_rate[%0d] got %0d cycles exp %0d",
                   i, got[i].cyc - got[i-1].cyc, e.len + 1);
        end
      end
      a = next_pc(e);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0]  s_op;
    logic [15:0] s_opd, s_pc;
    logic [1:0]  s_len;
    do_reset();
    wait_count(1, 20, ok);
    @(posedge clk); #1;
    instr_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout got no valid exp valid");
      instr_ready = 1'b1;
      return;
    end
    s_op = instr_opcode; s_opd = instr_operand; s_pc = instr_pc; s_len = instr_len;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (!instr_valid || instr_opcode !== s_op || instr_operand !== s_opd ||
          instr_pc !== s_pc || instr_len !== s_len || ps !== PS_HOLD || pc_cur !== 16'h0403) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b op=%h opd=%h pc=%h ps=%0d pc_cur=%h exp stable ps=HOLD pc_cur=0403",
                 i, instr_valid, instr_opcode, instr_operand, instr_pc, ps, pc_cur);
      end
    end
    checks++;
    if (s_op !== 8'hA9 || s_opd !== 16'h0042 || s_pc !== 16'h0401) begin
      errors++;
      $display("FAIL stall_instr got op=%h opd=%h pc=%h exp A9 0042 0401", s_op, s_opd, s_pc);
    end
    @(posedge clk); #1;
    instr_ready = 1'b1;
    wait_count(3, 30, ok);
    checks++;
    if (!ok || got[1].pc !== 16'h0401 || got[2].op !== 8'hAD || got[2].opd !== 16'h1234 ||
        got[2].pc !== 16'h0403) begin
      errors++;
      $display("FAIL stall_release got n=%0d exp A9@0401 then AD 1234 @0403", got.size());
    end
  endtask

  task automatic test_jmp();
    bit ok;
    logic [15:0] exp_pc;
`ifdef FETCH_JMP_REDIRECT_EN
    exp_pc = 16'h0500;
`else
    exp_pc = 16'h0409;
`endif
    do_reset();
    wait_count(5, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL jmp_timeout got %0d issues exp 5", got.size());
      return;
    end
    checks++;
    if (got[3].op !== 8'h4C || got[3].opd !== 16'h0500 || got[3].pc !== 16'h0406 || got[3].len !== 2'd3) begin
      errors++;
      $display("FAIL jmp_instr got op=%h opd=%h pc=%h exp 4C 0500 0406", got[3].op, got[3].opd, got[3].pc);
    end
    checks++;
    if (got[4].pc !== exp_pc) begin
      errors++;
      $display("FAIL jmp_next got pc=%h exp %h", got[4].pc, exp_pc);
    end
  endtask

  task automatic test_flush();
    bit ok;
    int n;
    do_reset();
    wait_count(2, 30, ok);
    @(posedge clk);
    @(posedge clk); #1;
    flush = 1'b1; flush_pc = 16'h0600;
    @(negedge clk);
    checks++;
    if (ps !== PS_ABS || pc_target !== 16'h0600) begin
      errors++;
      $display("FAIL flush_pcsel got ps=%0d tgt=%h exp ps=%0d tgt=0600", ps, pc_target, PS_ABS);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    wait_count(3, 30, ok);
    checks++;
    if (!ok || got[2].pc !== 16'h0600 || got[2].op !== 8'hA2 || got[2].opd !== 16'h0055) begin
      errors++;
      $display("FAIL flush_redirect got n=%0d exp A2 0055 @0600 with no AD", got.size());
      return;
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (instr_valid) begin ok = 1'b1; break; end
    end
    n = got.size();
    flush = 1'b1; flush_pc = 16'h0700;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_count(n + 2, 30, ok);
    checks++;
    if (!ok || got[n].pc !== 16'h0602 || got[n].op !== 8'hEA || got[n+1].pc !== 16'h0700 ||
        got[n+1].op !== 8'hE8) begin
      errors++;
      $display("FAIL flush_handshake got n=%0d exp EA@0602 once then E8@0700", got.size() - n);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem[16'hFFFE] = 8'hA9; mem[16'hFFFF] = 8'h77; mem[16'h0000] = 8'hEA;
    @(posedge clk); #1;
    flush = 1'b1; flush_pc = 16'hFFFE;
    @(posedge clk); #1;
    flush = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || instr_pc !== 16'hFFFE || instr_operand !== 16'h0077 || instr_opcode !== 8'hA9 ||
        instr_len !== 2'd2 || pc_cur !== 16'h0000) begin
      errors++;
      $display("FAIL wrap got v=%b op=%h opd=%h pc=%h pc_cur=%h exp A9 0077 FFFE pc_cur=0000",
               ok, instr_opcode, instr_operand, instr_pc, pc_cur);
    end
  endtask

  task automatic test_random();
    bit ok;
    int n0;
    issue_t e;
    logic [15:0] a, start;
    logic [7:0] op;
    logic [1:0] l;
    for (int r = 0; r < 4; r++) begin
      start = (r == 0) ? 16'hFFF0 : 16'($urandom);
      a = start;
      for (int k = 0; k < 30; k++) begin
        op = picks[$urandom_range(0, 33)];
        l  = ref_len(op);
        mem[a] = op;
        for (int b = 1; b < 3; b++) mem[a + 16'(b)] = 8'($urandom);
        a = a + {14'd0, l};
      end
      @(posedge clk); #1;
      instr_ready = 1'b0; flush = 1'b1; flush_pc = start;
      @(posedge clk); #1;
      flush = 1'b0;
      n0 = got.size();
      ok = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        instr_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
        if (got.size() >= n0 + 30) begin ok = 1'b1; break; end
      end
      instr_ready = 1'b1;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random[%0d]_timeout got %0d issues exp 30", r, got.size() - n0);
        continue;
      end
      a = start;
      for (int k = 0; k < 30; k++) begin
        expect_at(a, e);
        checks++;
        if (got[n0+k].op !== e.op || got[n0+k].len !== e.len || got[n0+k].opd !== e.opd ||
            got[n0+k].pc !== e.pc) begin
          errors++;
          $display("FAIL random[%0d][%0d] got op=%h len=%0d opd=%h pc=%h exp op=%h len=%0d opd=%h pc=%h",
                   r, k, got[n0+k].op, got[n0+k].len, got[n0+k].opd, got[n0+k].pc,
                   e.op, e.len, e.opd, e.pc);
        end
        a = next_pc(e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h0400] = 8'hEA;
    mem[16'h0401] = 8'hA9; mem[16'h0402] = 8'h42;
    mem[16'h0403] = 8'hAD; mem[16'h0404] = 8'h34; mem[16'h0405] = 8'h12;
    mem[16'h0406] = 8'h4C; mem[16'h0407] = 8'h00; mem[16'h0408] = 8'h05;
    mem[16'h0409] = 8'hC8;
    mem[16'h0500] = 8'hE8;
    mem[16'h0600] = 8'hA2; mem[16'h0601] = 8'h55;
    mem[16'h0700] = 8'hE8;

    test_reset();
    test_program();
    test_backpressure();
    test_jmp();
    test_flush();
    test_wrap();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
